pmod_dac_serializer: RTL

- Downstream output stage of filter_top.
- Takes two signed 16-bit sample streams (desired-filter output and adaptive-filter output/error) and converts each to a 12-bit offset-binary code.
- Shifts both codes out simultaneously as 16-bit SPI frames to a dual-channel PMOD DAC (DAC121S101-style) on header JA, so the waveforms can be viewed on a scope.

---
 rtl/pmod_dac_serializer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pmod_dac_serializer.sv
// ---------------------------------------------------------------------------
// pmod_dac_serializer
//
// Output stage of filter_top. It takes two signed 16-bit sample streams,
// converts each one to a 12-bit offset-binary DAC code and shifts both codes
// out at the same time. Each code goes out as a 16-bit SPI frame to a
// dual-channel DAC121S101-style PMOD, so both waveforms can be viewed on a
// scope.
//
// Frame format: {4'b0000, code[11:0]}, sent MSB first. The top four bits
// select the DAC's normal operating mode. code = {~s[15], s[14:4]}, which
// truncates the sample and does not round it.
//
// Parameters
//   CLK_DIV     system clocks per sclk half-period (>= 2)
//   GAP_CYCLES  clocks that sync_n is held high between frames (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   sample_a/b    signed two's-complement samples, channels A and B
//   sample_valid  one-cycle strobe; both samples are valid this cycle
//   sync_n        DAC frame sync, active low
//   sclk          DAC serial clock, idles high
//   dina/dinb     serial data for channels A and B, MSB first
//   busy          high while a frame or the inter-frame gap is in progress
//   frame_done    one-cycle pulse when sync_n returns high at the end of a frame
//   overrun       one-cycle pulse when a pending sample pair is overwritten
// ---------------------------------------------------------------------------
module pmod_dac_serializer #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample_a,
  input  logic [15:0] sample_b,
  input  logic        sample_valid,
  output logic        sync_n,
  output logic        sclk,
  output logic        dina,
  output logic        dinb,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam logic [HC_W-1:0] HALF_LAST = HC_W'(CLK_DIV - 1);
  localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_CYCLES - 1);
  localparam logic [4:0]      FRAME_BITS = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  // Offset-binary conversion: flipping the sign bit maps -32768..32767 onto
  // 0..65535. Only the top 12 bits are kept.
  function automatic logic [15:0] to_frame(input logic [15:0] s);
    return {4'b0000, ~s[15], s[14:4]};
  endfunction

  state_t          state;
  logic [HC_W-1:0] half_cnt;   // clocks elapsed in the current sclk half-period
  logic [GC_W-1:0] gap_cnt;    // clocks elapsed in the inter-frame gap
  logic [4:0]      fall_cnt;   // sclk falling edges seen in this frame
  logic [15:0]     sr_a;
  logic [15:0]     sr_b;

  // One-deep pending buffer. It holds a sample pair that arrives while a
  // frame is being sent.
  logic            pend_valid;
  logic [15:0]     pend_a;
  logic [15:0]     pend_b;

  // Start selection. The pending pair is older than a pair arriving in the
  // same cycle, so it goes out first.
  logic            start_pend;
  logic            start_new;
  logic [15:0]     start_frame_a;
  logic [15:0]     start_frame_b;

  // NOTE: every signal is assigned on every path through this block, so no
  // latch can be inferred.
  always_comb begin
    start_pend    = (state == IDLE) && pend_valid;
    start_new     = (state == IDLE) && !pend_valid && sample_valid;
    start_frame_a = start_pend ? to_frame(pend_a) : to_frame(sample_a);
    start_frame_b = start_pend ? to_frame(pend_b) : to_frame(sample_b);
  end

  // NOTE: all state is updated with non-blocking assignments. This way every
  // register samples the values from before the edge, whatever the statement
  // order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      fall_cnt   <= '0;
      sr_a       <= '0;
      sr_b       <= '0;
      pend_valid <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
      sync_n     <= 1'b1;
      sclk       <= 1'b1;
      dina       <= 1'b0;
      dinb       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      // Pending buffer. A pair that arrives while busy is stored here, and
      // overwriting a full buffer reports an overrun. In IDLE with the buffer
      // full, the pending pair starts now and the new pair takes its slot.
      if (sample_valid) begin
        if (state != IDLE) begin
          pend_a     <= sample_a;
          pend_b     <= sample_b;
          pend_valid <= 1'b1;
          overrun    <= pend_valid;
        end else if (pend_valid) begin
          pend_a     <= sample_a;
          pend_b     <= sample_b;
        end
      end else if (start_pend) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_pend || start_new) begin
            sr_a     <= start_frame_a;
            sr_b     <= start_frame_b;
            dina     <= start_frame_a[15];
            dinb     <= start_frame_b[15];
            sync_n   <= 1'b0;
            sclk     <= 1'b1;
            busy     <= 1'b1;
            half_cnt <= '0;
            fall_cnt <= '0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (sclk) begin
              // Falling edge: the DAC samples dina/dinb here.
              sclk     <= 1'b0;
              fall_cnt <= fall_cnt + 5'd1;
            end else if (fall_cnt == FRAME_BITS) begin
              // Rising edge after the last bit ends the frame.
              sclk       <= 1'b1;
              sync_n     <= 1'b1;
              dina       <= 1'b0;
              dinb       <= 1'b0;
              frame_done <= 1'b1;
              gap_cnt    <= '0;
              state      <= GAP;
            end else begin
              // Rising edge: move on to the next bit, well clear of the next
              // falling edge.
              sclk <= 1'b1;
              sr_a <= {sr_a[14:0], 1'b0};
              sr_b <= {sr_b[14:0], 1'b0};
              dina <= sr_a[14];
              dinb <= sr_b[14];
            end
          end else begin
            half_cnt <= half_cnt + HC_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GC_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
